// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the mux8_arbiter round-robin selector sequencer.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // One-hot grant vector for a selector address.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping 7 -> 0. Shared by the IDLE and RELEASE decisions of the arbiter.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the closest set bit to ptr wins.
  always_comb begin
    winner = ptr;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) winner = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter driving a part_74S151 8-to-1 selector (sel -> SEL2..SEL0,
// ce_n -> CE_N). Every owner change passes through one disabled RELEASE cycle
// so sel never moves while the selector is enabled.
// Optional feature: define MUX8_ARB_BURST_LIMIT_EN to cap a grant at MAX_BURST
// cycles whenever another requester is waiting.
//
// Request/grant protocol: a requester holds req[i] high until it sees gnt[i];
// it keeps ownership for as long as req[i] stays high (subject to the burst
// cap), and dropping req[i] on any cycle ends ownership at the next edge.
module mux8_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             ce_n,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  if (MAX_BURST < 2 || MAX_BURST > 256) begin : g_bad_max_burst
    $error("mux8_arbiter: MAX_BURST must be in 2..256");
  end

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] pick_winner;
  logic             pick_any;
  logic             burst_expire;
  logic             release_now;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_winner),
    .any    (pick_any)
  );

`ifdef MUX8_ARB_BURST_LIMIT_EN
  localparam logic [8:0] BURST_LAST = 9'(MAX_BURST - 1);
  logic [8:0] burst_cnt;

  // The cap only bites when someone else is waiting; alone, the owner keeps going.
  assign burst_expire = (burst_cnt == BURST_LAST) && ((req & ~gnt) != '0);

  // Grant-cycle counter: cleared on entry to GRANT, saturates at BURST_LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= '0;
    end else if (state != GRANT) begin
      if (pick_any) burst_cnt <= '0;
    end else if (burst_cnt != BURST_LAST) begin
      burst_cnt <= burst_cnt + 9'd1;
    end
  end
`else
  assign burst_expire = 1'b0;
`endif

  // In GRANT the owner's address is held in sel, so req[sel] is the owner's request.
  assign release_now = (state == GRANT) && (!req[sel] || burst_expire);
  assign fsm_state   = state;

  // Arbiter state machine with registered selector controls and grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      ce_n  <= 1'b1;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (pick_any) begin
            state <= GRANT;
            sel   <= pick_winner;
            gnt   <= onehot(pick_winner);
            ce_n  <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            gnt   <= '0;
            ce_n  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state <= RELEASE;
            ptr   <= sel + 3'd1;
            gnt   <= '0;
            ce_n  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          ce_n  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// Self-checking bench for mux8_arbiter: directed scenarios plus a long random
// run, all compared against a behavioural owner/pointer model.
module tb_mux8_arbiter;
  import mux8_arb_pkg::IDLE;

  localparam int MAX_B = 4;
`ifdef MUX8_ARB_BURST_LIMIT_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       ce_n;
  logic       busy;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  // Model: current owner (-1 = none), pointer, held cycles, dead-cycle flag, last select.
  int m_owner = -1;
  int m_ptr = 0;
  int m_held = 0;
  bit m_dead = 1'b0;
  int m_sel = 0;

  logic [7:0] exp_q[$];

  mux8_arbiter #(.MAX_BURST(MAX_B)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .ce_n      (ce_n),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assert property (@(posedge clk) disable iff (!reset_n) !$past(ce_n) |-> $stable(sel))
    else $error("FAIL sel_stable_assert sel=%0d", sel);

  // ---------------- reference model ----------------
  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] e_gnt();
    return (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
  endfunction
  function automatic logic e_ce_n();
    return (m_owner < 0);
  endfunction
  function automatic logic e_busy();
    return (m_owner >= 0) || m_dead;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_dead = 1'b0; m_sel = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] others;
    if (m_owner >= 0) begin
      others = r & ~(8'h01 << m_owner);
      if (!r[m_owner] || (BURST_ON && m_held >= MAX_B && others != 8'h00)) begin
        m_ptr = (m_owner + 1) % 8;
        m_owner = -1;
        m_dead = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_dead = 1'b0;
      if (r != 8'h00) begin
        m_owner = pick(r, m_ptr);
        m_sel = m_owner;
        m_held = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic apply_reset();
    req = 8'h00;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req = 8'h00;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ce_n !== 1'b1) begin errors++; $display("FAIL reset_ce_n got=%b exp=1", ce_n); end
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    tick(8'h08);
    checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL single_gnt got=%h exp=08", gnt); end
    checks++; if (sel !== 3'd3) begin errors++; $display("FAIL single_sel got=%0d exp=3", sel); end
    checks++; if (ce_n !== 1'b0) begin errors++; $display("FAIL single_ce_n got=%b exp=0", ce_n); end
    for (int i = 2; i <= 4; i++) begin
      tick(8'h08);
      checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL single_hold_%0d got=%h exp=08", i, gnt); end
    end
    tick(8'h00);
    checks++; if (ce_n !== 1'b1 || gnt !== 8'h00 || busy !== 1'b1) begin
      errors++; $display("FAIL single_release ce_n=%b gnt=%h busy=%b exp 1/00/1", ce_n, gnt, busy);
    end
    tick(8'h00);
    checks++; if (fsm_state !== IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL single_idle state=%0d busy=%b exp %0d/0", fsm_state, busy, IDLE);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] r;
    logic [7:0] prev_gnt;
    logic [7:0] want;
    int held;
    int dead;
    apply_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h01 << i);
    exp_q.push_back(8'h01);
    held = 0; dead = 0; prev_gnt = 8'h00;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      r = (gnt != 8'h00 && held >= 2) ? (8'hFF & ~gnt) : 8'hFF;
      tick(r);
      checks++; if (gnt !== e_gnt() || ce_n !== e_ce_n()) begin
        errors++; $display("FAIL rr_model c=%0d gnt=%h ce_n=%b exp %h/%b", c, gnt, ce_n, e_gnt(), e_ce_n());
      end
      if (gnt != 8'h00 && prev_gnt == 8'h00) begin
        want = exp_q.pop_front();
        checks++; if (gnt !== want) begin errors++; $display("FAIL rr_order got=%h exp=%h", gnt, want); end
        if (c > 1) begin
          checks++; if (dead != 1) begin errors++; $display("FAIL rr_dead got=%0d exp=1", dead); end
        end
        dead = 0;
      end
      if (gnt == 8'h00) dead++;
      held = (gnt != 8'h00) ? held + 1 : 0;
      prev_gnt = gnt;
    end
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_timeout remaining=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    tick(8'h40);
    checks++; if (gnt !== 8'h40) begin errors++; $display("FAIL wrap_g6 got=%h exp=40", gnt); end
    tick(8'h00);
    tick(8'h21);
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL wrap_first got=%h exp=01", gnt); end
    tick(8'h20);
    checks++; if (gnt !== 8'h00 || ce_n !== 1'b1) begin
      errors++; $display("FAIL wrap_dead gnt=%h ce_n=%b exp 00/1", gnt, ce_n);
    end
    tick(8'h20);
    checks++; if (gnt !== 8'h20 || sel !== 3'd5) begin
      errors++; $display("FAIL wrap_second gnt=%h sel=%0d exp 20/5", gnt, sel);
    end
    tick(8'h00);
  endtask

  task automatic test_burst();
    logic [7:0] exp_b[10];
    apply_reset();
    for (int i = 0; i < 10; i++) exp_b[i] = 8'h01;
    if (BURST_ON) begin
      for (int i = 0; i < 4; i++) exp_b[i] = 8'h01;
      exp_b[4] = 8'h00;
      for (int i = 5; i < 9; i++) exp_b[i] = 8'h02;
      exp_b[9] = 8'h00;
    end
    for (int i = 0; i < 10; i++) begin
      tick(8'h03);
      checks++; if (gnt !== exp_b[i]) begin
        errors++; $display("FAIL burst_cycle%0d got=%h exp=%h", i + 1, gnt, exp_b[i]);
      end
    end
    tick(8'h00);
    tick(8'h00);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tick(8'h01);
    tick(8'h00);
    tick(8'h10);
    checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL midrst_pre got=%h exp=10", gnt); end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (gnt !== 8'h00 || ce_n !== 1'b1) begin
      errors++; $display("FAIL midrst_async gnt=%h ce_n=%b exp 00/1", gnt, ce_n);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(8'h11);
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL midrst_ptr got=%h exp=01", gnt); end
    tick(8'h00);
    tick(8'h10);
    checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL midrst_g4 got=%h exp=10", gnt); end
    tick(8'h00);
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [2:0] prev_sel;
    logic       prev_ce_n;
    apply_reset();
    r = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 1) == 0) r = 8'($urandom_range(0, 255));
      prev_sel = sel;
      prev_ce_n = ce_n;
      tick(r);
      checks++; if (gnt !== e_gnt() || ce_n !== e_ce_n() || busy !== e_busy()) begin
        errors++;
        $display("FAIL rand_model c=%0d req=%h gnt=%h ce_n=%b busy=%b exp %h/%b/%b",
                 c, r, gnt, ce_n, busy, e_gnt(), e_ce_n(), e_busy());
      end
      if (m_owner >= 0) begin
        checks++; if (sel !== 3'(m_sel)) begin
          errors++; $display("FAIL rand_sel c=%0d got=%0d exp=%0d", c, sel, m_sel);
        end
      end
      if (prev_ce_n == 1'b0) begin
        checks++; if (sel !== prev_sel) begin
          errors++; $display("FAIL rand_sel_stable c=%0d got=%0d exp=%0d", c, sel, prev_sel);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_burst();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_arbiter.md
# mux8_arbiter

Round-robin arbiter and select sequencer for a `part_74S151` 8-to-1 selector. Eight requesters share the selector's single output bit. The block grants one requester at a time and drives the selector's `SEL2..SEL0` and `CE_N` from registers. It inserts one disabled cycle on every owner change so the select lines never move while the selector is enabled.

## Interface
- `MAX_BURST`, 16: maximum consecutive grant cycles while another request is pending. Used only with `MUX8_ARB_BURST_LIMIT_EN`. Legal range is 2..256.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  8: request per requester; bit i corresponds to selector input Ii.
- `gnt`  out  8: one-hot grant, registered.
- `sel`  out  3: selector address, registered; wired to `SEL2`..`SEL0`.
- `ce_n`  out  1: selector enable, active-low, registered; wired to `CE_N`.
- `busy`  out  1: high in GRANT and RELEASE.

## Operation
- **State machine.** There are three states: IDLE, GRANT and RELEASE.
- **IDLE.**
  - Outputs: `ce_n`=1, `gnt`=0.
  - If `req`≠0, pick a winner W and go to GRANT.
  - Otherwise stay in IDLE.
- **Winner selection.**
  - W is the first set bit of `req`, scanning upward from pointer `ptr` and wrapping 7→0.
- **GRANT.**
  - Outputs: `sel`=W, `ce_n`=0, `gnt`=1<<W.
  - The grant stays in place while `req[W]`=1.
  - When `req[W]`=0, go to RELEASE and set `ptr`←(W+1) mod 8.
- **RELEASE.**
  - Outputs: `ce_n`=1, `gnt`=0, `sel` holds W.
  - Next state is the same decision as IDLE: if any request is pending, pick a new winner and go to GRANT; otherwise go to IDLE.
- **Select stability.** `sel` changes only on the edge that enters GRANT, and only while `ce_n` has been 1 for at least one cycle.
- **Request handling.**
  - A requester re-asserting immediately after release is served last among those pending, because the pointer has moved past it.
  - `req` bits other than W are ignored during GRANT.
- **Reset values.**
  - State IDLE, `ptr`=0, `sel`=0, `ce_n`=1, `gnt`=0, `busy`=0, burst counter 0.
  - Reset asserted mid-grant drops `gnt` and raises `ce_n` immediately, without waiting for a clock edge.

## Timing
- **Grant latency.** `req` sampled high at edge k gives `gnt`/`ce_n` valid after edge k.
- **Release latency.**
  - `req[W]` sampled low at edge k gives `gnt`=0 after edge k.
  - The next grant, if any request is pending, is valid after edge k+1.
- **Dead cycle.** Exactly one dead cycle separates back-to-back owners.
- **Single requester.**
  - A requester holding `req` continuously keeps the grant indefinitely, unless the burst limit below applies.
  - It regains the grant after a one-cycle RELEASE if it drops and re-raises `req` in consecutive cycles.
- **Simultaneous events.** If `req[W]` drops in the same cycle that the burst limit expires, the result is treated as a normal release, with the same pointer update.

## Configuration
- **Macro:** `MUX8_ARB_BURST_LIMIT_EN`.
- **Defined:**
  - A counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches `MAX_BURST`-1 and any other `req` bit is set, the next edge forces RELEASE.
  - The pointer advances as for a normal release.
  - The requester sees `gnt` fall while its `req` is still high, and must hold or re-raise `req` to regain the grant.
  - With no other requester pending, the counter saturates and the grant continues.
- **Undefined:**
  - No counter logic is present.
  - `MAX_BURST` is ignored.
  - The grant is held until the owner drops `req`.

## Structure
- **Package `mux8_arb_pkg`:**
  - State enum (IDLE/GRANT/RELEASE).
  - `N_REQ`=8 and `SEL_W`=3.
- **Sub-module `rr_pick8`:**
  - Combinational.
  - Inputs: `req[7:0]` and `ptr[2:0]`.
  - Outputs: `winner[2:0]` and `any`.
  - Reused by the IDLE and RELEASE decisions.
- The arbiter does not instantiate the selector. The parent wires `sel`/`ce_n` to a `part_74S151` instance.

## Test plan
- **Reset and single request.**
  - During reset: `ce_n`=1, `gnt`=0, `sel`=0.
  - Stimulus: after reset, `req`=8'h08 at edge 1.
  - Required response: `gnt`=8'h08, `sel`=3, `ce_n`=0 after edge 1.
  - Stimulus: drop `req` at edge 5.
  - Required response: `ce_n`=1 after edge 5, IDLE after edge 6.
- **Round-robin order.**
  - Stimulus: `req`=8'hFF held, each owner dropping its bit for one cycle after 2 granted cycles.
  - Required response: grant order 0,1,2,…,7,0, with one `ce_n`=1 cycle between owners.
- **Wrap-around.**
  - Stimulus: after serving 6, `req`=8'h21.
  - Required response: grant goes to 0 before 5.
- **Burst limit** (macro defined, `MAX_BURST`=4).
  - Stimulus: `req`=8'h03 held.
  - Required response: requester 0 granted 4 cycles, 1 dead cycle, requester 1 granted 4 cycles.
  - Without the macro: requester 0 is granted indefinitely.
- **Reset mid-grant.**
  - Stimulus: assert `reset_n`=0 asynchronously while `gnt`=8'h10.
  - Required response: `gnt`=0 and `ce_n`=1 before the next clock edge.
  - After release of reset: next grant to `req`=8'h10 starts from `ptr`=0.
- **Select stability.**
  - Check: an assertion that `sel` never changes in a cycle where `ce_n` was 0 in the preceding cycle, over 10k random-`req` cycles.
